// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage.
//   - opcode ranges selecting the access size (word 3-5, half 6-8, byte 9-11)
//   - access-size and FSM state enums
//   - NONE_EXC: exception code meaning "no exception"
//   - op_size(): maps an opcode onto its access size
package mem_stage_pkg;

    localparam logic [7:0] NONE_EXC   = 8'h00;

    localparam logic [4:0] OP_WORD_LO = 5'd3;
    localparam logic [4:0] OP_WORD_HI = 5'd5;
    localparam logic [4:0] OP_HALF_LO = 5'd6;
    localparam logic [4:0] OP_HALF_HI = 5'd8;
    localparam logic [4:0] OP_BYTE_LO = 5'd9;
    localparam logic [4:0] OP_BYTE_HI = 5'd11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        DRAIN     = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_BYTE = 2'd2
    } size_t;

    // Opcodes outside the memory ranges fall back to word size; their
    // enables are never used because no request is issued for them.
    function automatic size_t op_size(input logic [4:0] opcode);
        if (opcode >= OP_WORD_LO && opcode <= OP_WORD_HI) return SIZE_WORD;
        if (opcode >= OP_HALF_LO && opcode <= OP_HALF_HI) return SIZE_HALF;
        if (opcode >= OP_BYTE_LO && opcode <= OP_BYTE_HI) return SIZE_BYTE;
        return SIZE_WORD;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port bundle between the memory stage (master) and the
// data memory (slave).
//   req    master->slave  request valid
//   ready  slave->master  request accepted this cycle
//   we     master->slave  byte write enables (0 for loads)
//   addr   master->slave  word-aligned address
//   wdata  master->slave  lane-shifted store data
//   rvalid slave->master  load response valid
//   rdata  slave->master  load response word
//
// Handshake: a request transfers on every clock edge where req && ready are
// both high; while req is high and ready is low, we/addr/wdata stay stable
// and req stays high. A load response is a single-cycle rvalid pulse that
// arrives at least one cycle after the accepting edge and is never
// back-pressured.
interface mem_stage_if;
    logic        req;
    logic        ready;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input ready, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment for a 32-bit data port.
//   size      in   access size (word/half/byte)
//   offset    in   effective address bits [1:0]
//   data      in   right-aligned store value
//   byte_en   out  byte enables for the addressed lanes
//   lane_data out  store value shifted onto the addressed lanes
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  size_t       size,
    input  logic [1:0]  offset,
    input  logic [31:0] data,
    output logic [3:0]  byte_en,
    output logic [31:0] lane_data
);

    always_comb begin
        byte_en   = 4'b1111;
        lane_data = data;
        case (size)
            SIZE_HALF: begin
                // Offset 01 straddles the middle lanes; 10 and 11 both map
                // to the upper half.
                if (offset[1]) begin
                    byte_en   = 4'b1100;
                    lane_data = {data[15:0], 16'h0000};
                end else if (offset[0]) begin
                    byte_en   = 4'b0110;
                    lane_data = {8'h00, data[15:0], 8'h00};
                end else begin
                    byte_en   = 4'b0011;
                    lane_data = {16'h0000, data[15:0]};
                end
            end
            SIZE_BYTE: begin
                byte_en   = 4'b0001 << offset;
                lane_data = {24'h000000, data[7:0]} << {offset, 3'b000};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage between execute and writeback.
//   clk, rst            clock, asynchronous active-high reset
//   clk_en, halt        freeze controls; nothing changes unless clk_en && !halt
//   flush               squash the instruction in this stage
//   *_in                execute-stage slot (alu_result_1_in is the address)
//   dmem                data-memory request/response port (master side)
//   stall_out           hold upstream stages and keep *_in stable
//   *_out               registered slot for writeback; mem_result_out holds
//                       the raw load word, writeback extracts the lane
//   state_dbg           current FSM state
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    input  logic               halt,
    input  logic               flush,
    input  logic               bubble_in,
    input  logic [4:0]         opcode_in,
    input  logic [4:0]         tgt_in_1,
    input  logic [4:0]         tgt_in_2,
    input  logic               is_load_in,
    input  logic               is_store_in,
    input  logic [31:0]        alu_result_1_in,
    input  logic [31:0]        alu_result_2_in,
    input  logic [31:0]        store_data_in,
    input  logic [7:0]         exc_in,
    input  logic               tgts_cr_in,
    input  logic [4:0]         priv_type_in,
    input  logic [1:0]         crmov_mode_type_in,
    mem_stage_if.master        dmem,
    output logic               stall_out,
    output logic               bubble_out,
    output logic [4:0]         tgt_out_1,
    output logic [4:0]         tgt_out_2,
    output logic [4:0]         opcode_out,
    output logic               is_load_out,
    output logic               is_store_out,
    output logic [31:0]        alu_result_1_out,
    output logic [31:0]        alu_result_2_out,
    output logic [31:0]        mem_result_out,
    output logic [31:0]        addr_out,
    output logic [7:0]         exc_out,
    output logic               tgts_cr_out,
    output logic [4:0]         priv_type_out,
    output logic [1:0]         crmov_mode_type_out,
    output state_t             state_dbg
);

    state_t      state, next_state;
    logic        adv, mem_op, req, stall, load_done;
    logic [3:0]  byte_en;
    logic [31:0] lane_data;

    assign adv    = clk_en && !halt;
    assign mem_op = !bubble_in && (is_load_in || is_store_in) &&
                    (exc_in == NONE_EXC) && !flush;

    mem_lane_align u_align (
        .size      (op_size(opcode_in)),
        .offset    (alu_result_1_in[1:0]),
        .data      (store_data_in),
        .byte_en   (byte_en),
        .lane_data (lane_data)
    );

    assign dmem.req   = req;
    assign dmem.we    = is_store_in ? byte_en : 4'b0000;
    assign dmem.addr  = {alu_result_1_in[31:2], 2'b00};
    assign dmem.wdata = lane_data;
    assign stall_out  = stall;
    assign state_dbg  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else if (adv) state <= next_state;
    end

    always_comb begin
        next_state = state;
        req        = 1'b0;
        stall      = 1'b0;
        load_done  = 1'b0;
        case (state)
            IDLE: begin
                req = adv && mem_op;
                if (req) begin
                    // An accepted load also stalls: its slot must not reach
                    // writeback until the data returns.
                    if (!dmem.ready) begin
                        stall = 1'b1;
                    end else if (is_load_in) begin
                        stall      = 1'b1;
                        next_state = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                stall = !dmem.rvalid;
                if (adv) begin
                    if (dmem.rvalid) begin
                        load_done  = 1'b1;
                        next_state = IDLE;
                    end else if (flush) begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Stall through the response cycle too: the instruction now
                // waiting in execute has not issued yet and must not slip
                // into writeback without its access.
                stall = 1'b1;
                if (adv && dmem.rvalid) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_out          <= 1'b1;
            tgt_out_1           <= '0;
            tgt_out_2           <= '0;
            opcode_out          <= '0;
            is_load_out         <= 1'b0;
            is_store_out        <= 1'b0;
            alu_result_1_out    <= '0;
            alu_result_2_out    <= '0;
            mem_result_out      <= '0;
            addr_out            <= '0;
            exc_out             <= '0;
            tgts_cr_out         <= 1'b0;
            priv_type_out       <= '0;
            crmov_mode_type_out <= '0;
        end else if (adv) begin
            if (stall) begin
                bubble_out <= 1'b1;
            end else begin
                bubble_out          <= bubble_in || flush;
                tgt_out_1           <= tgt_in_1;
                tgt_out_2           <= tgt_in_2;
                opcode_out          <= opcode_in;
                is_load_out         <= is_load_in;
                is_store_out        <= is_store_in;
                alu_result_1_out    <= alu_result_1_in;
                alu_result_2_out    <= alu_result_2_in;
                mem_result_out      <= load_done ? dmem.rdata : 32'h0;
                addr_out            <= alu_result_1_in;
                exc_out             <= exc_in;
                tgts_cr_out         <= tgts_cr_in;
                priv_type_out       <= priv_type_in;
                crmov_mode_type_out <= crmov_mode_type_in;
            end
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage sitting between execute and writeback.
- Issues load/store requests to the data-memory port through a valid/ready request and rvalid response handshake.
- Forms byte enables and lane-shifted store data, and stalls the pipe while an access is outstanding.
- Registers everything writeback consumes (targets, ALU results, raw memory word, address, exception/privilege fields), so writeback performs the load lane-extraction itself.

Parameters:
- NONE_EXC, 8'h00, exception code meaning "no exception"; any other exc_in value suppresses the memory access.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- clk_en  in  1  global clock enable; no state or output register changes when low
- halt  in  1  pipeline halt; same freeze effect as clk_en low
- flush  in  1  squash the instruction in this stage (exception/rfe taken in writeback)
- bubble_in  in  1  the execute-stage slot is empty
- opcode_in  in  5  instruction opcode: 3-5 word, 6-8 halfword, 9-11 byte access
- tgt_in_1, tgt_in_2  in  5  register targets
- is_load_in, is_store_in  in  1  access type
- alu_result_1_in, alu_result_2_in  in  32  execute results; alu_result_1_in is the effective address for memory ops
- store_data_in  in  32  store source value, right-aligned
- exc_in  in  8  exception code from earlier stages
- tgts_cr_in  in  1  control-register target flag
- priv_type_in  in  5  privileged-op subtype
- crmov_mode_type_in  in  2  privileged-op mode
- dmem_req  out  1  request valid
- dmem_ready  in  1  memory accepts the request this cycle
- dmem_we  out  4  byte write enables; 0 for loads
- dmem_addr  out  32  word address: effective address with bits [1:0] forced to 0
- dmem_wdata  out  32  lane-shifted store data
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data word
- stall_out  out  1  hold upstream stages and inputs stable
- bubble_out, tgt_out_1, tgt_out_2, opcode_out, is_load_out, is_store_out, alu_result_1_out, alu_result_2_out, mem_result_out, addr_out, exc_out, tgts_cr_out, priv_type_out, crmov_mode_type_out  out  (widths as inputs; mem_result_out 32)  registered writeback inputs

Behaviour:
- Reset (async): state=IDLE; bubble_out=1; all other registered outputs 0; dmem_req=0.
- mem_op = !bubble_in && (is_load_in || is_store_in) && exc_in==NONE_EXC && !flush.
- Every handshake output and state transition is qualified by adv = clk_en && !halt. When adv is low, dmem_req=0 and state holds.
- Byte enables:
  - Word: 1111.
  - Halfword: addr[1:0]=00 gives 0011; 01 gives 0110; 1x gives 1100.
  - Byte: 0001 shifted left by addr[1:0].
- Store data lane shift:
  - Word: unshifted.
  - Halfword: data[15:0] shifted left by 0, 8 or 16 bits matching the enables above.
  - Byte: data[7:0] shifted left by 8*addr[1:0].
- dmem_we = is_store ? enables : 0.
- FSM states: IDLE, WAIT_DATA, DRAIN.
  - IDLE: dmem_req = adv && mem_op, driven combinationally.
    - Store accepted (ready=1): completes this cycle, no stall, outputs latch at the edge.
    - Load accepted: go to WAIT_DATA.
    - Request not accepted: stay IDLE with req held; stall_out=1.
  - WAIT_DATA: dmem_req=0; stall_out = !dmem_rvalid.
    - On rvalid: capture rdata into mem_result_out with the rest of the slot, then go to IDLE.
    - Response latency is at least 1 cycle after acceptance. rvalid in the acceptance cycle is illegal.
  - DRAIN: entered when flush is asserted in WAIT_DATA. stall_out=1 until rvalid; the response data is discarded; bubble_out=1; then go to IDLE.
  - rvalid while in IDLE is ignored.
- Output register load: when adv && !stall_out, capture all *_in fields into *_out.
  - bubble_out = bubble_in || flush.
  - mem_result_out = dmem_rdata on the load's completing edge, otherwise 0.
  - addr_out = full effective address.
- When stall_out=1 with adv high, the output registers load a bubble (bubble_out=1, other fields hold), so writeback never sees a duplicate.
- Non-memory ops and excepting ops pass through in 1 cycle with no request.
- Exceptions are passed through unmodified.
- flush in IDLE suppresses the request and produces a bubble.
- Reset mid-access: immediate return to IDLE; any later stray rvalid is ignored.

Decomposition:
- Shared package holds:
  - opcode-range constants (word 3-5, half 6-8, byte 9-11);
  - state enum;
  - NONE_EXC.
- Sub-module mem_lane_align: combinational addr[1:0]/size to byte-enable plus store-data shift; reusable by a future cache.

Test Plan:
- Store byte, addr=0x1003, data=0xAB, ready=1 -> dmem_we=1000, wdata=0xAB000000, dmem_addr=0x1000, no stall, bubble_out=0 next cycle.
- Load word, addr=0x2000, ready=1, rvalid after 3 cycles with 0xDEADBEEF -> stall_out=1 for 3 cycles, then mem_result_out=0xDEADBEEF, addr_out=0x2000, exactly one non-bubble output.
- Store half at addr 0x01 with ready low for 2 cycles -> dmem_req held 3 cycles, we=0110, wdata = data[15:0]<<8, stall_out=1 for 2 cycles.
- exc_in=8'h82 on a load -> no dmem_req; exc_out=8'h82 next cycle; no stall.
- Load accepted, flush next cycle, rvalid 2 cycles later -> DRAIN, stall_out held until rvalid, bubble_out=1, data dropped, next instruction issues after.
- Assert rst during WAIT_DATA, then a stray rvalid -> bubble_out=1, state IDLE, rvalid ignored; halt=1 -> outputs frozen, dmem_req=0.
